mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single synchronous memory port between the instruction-fetch path and the load/store data path. Each cycle it arbitrates between the two requesters and drives the memory address, write-enable and write data from the winner. It routes the read data returned one cycle later back to the requester that owns it, and raises a stall to the core sequencer while a data access is pending. Data has priority over fetch; a starvation counter guarantees fetch forward progress.

## Interface
- `DATA_W`, 16: memory word width.
- `ADDR_W`, 16: byte-address width from both requesters.
- `STARVE_LIM`, 4: consecutive data grants allowed while fetch waits; range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held with `if_addr` stable until granted; may drop ungranted (branch cancel).
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  DATA_W  fetch read data.
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` stable until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  DATA_W  load data.
- `mem_addr`  out  ADDR_W-1  word address = granted byte address >> 1.
- `mem_wr`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after the address is presented.
- `mem_sel`  out  1  0 = port driven for fetch, 1 = port driven for data.
- `stall`  out  1  core must hold; data access not yet complete.

## Operation
- Grant decision is combinational from the current requests and the registered starvation count. At most one grant per cycle.
- Priority:
  - `d_req` wins.
  - Exception: if `if_req` is high and `starve_cnt == STARVE_LIM`, fetch wins.
  - Fetch is granted only when `d_req` is low or the exception applies.
- Starvation counter `starve_cnt`:
  - increments on each data grant while `if_req` is high, saturating at `STARVE_LIM`;
  - clears on any fetch grant or any cycle with `if_req` low.
- Port drive:
  - Granted requester's address, `d_we` and wdata go to `mem_addr`, `mem_wr` and `mem_wdata`.
  - With no grant: `mem_wr = 0` and `mem_addr`/`mem_wdata` hold their last value.
  - Byte address bit 0 is ignored.
- Owner FSM records the outstanding read. States:
  - `IDLE`: no read outstanding.
  - `RD_IF`: fetch read outstanding.
  - `RD_D`: data read outstanding.
- Next state is set by the grant in the current cycle, independent of the current state:
  - fetch grant → `RD_IF`;
  - data load grant → `RD_D`;
  - store grant or no grant → `IDLE`.
  - Back-to-back grants are therefore legal (throughput 1/cycle).
- Read return:
  - In `RD_IF`, `if_rvalid = 1` and `if_rdata = mem_rdata`.
  - In `RD_D`, `d_rvalid = 1` and `d_rdata = mem_rdata`.
  - Returned data is also captured, so each `*_rdata` holds its last value after its rvalid.
- Stores complete in the grant cycle; no rvalid is issued.
- `stall = (d_req & ~d_gnt) | (d_gnt & ~d_we)`. It is low in the `d_rvalid` cycle.
- `mem_sel = 1` when data is granted, 0 otherwise.

## Timing
- Reset (async assert, release sync to `clk`):
  - state `IDLE`, `starve_cnt = 0`;
  - all outputs 0, including held `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`.
- Latency:
  - grant in cycle N; read data and rvalid in cycle N+1.
  - store write takes effect at the end of cycle N.
- Fetch dropped in the cycle it would have been granted: no grant and no rvalid.
- Fetch dropped after grant: rvalid still issued in N+1; the consumer discards it.
- Simultaneous `d_req` and `if_req` with the counter below the limit: data granted, fetch waits.
- Reset asserted with a read outstanding: no rvalid is ever produced for it.

## Structure
- Package `mem_arb_pkg`:
  - `owner_e` enum {`IDLE`, `RD_IF`, `RD_D`};
  - `MEM_DATA_W`, `MEM_ADDR_W` defaults.
- Sub-module `arb_starve_ctr`: saturating counter, inputs `inc`, `clr`, parameter `LIM`, output `at_lim`.
- Grant logic, port mux and owner FSM stay in the top module.

## Test plan
- Fetch only, `if_addr = 0x0010`, memory word 8 = `0xA5C3`:
  - `if_gnt` in cycle N, `mem_addr = 0x008`, `mem_sel = 0`;
  - `if_rvalid` with `if_rdata = 0xA5C3` in N+1.
- Load at `0x0020` while `if_req` is high:
  - `d_gnt`, `stall = 1` in N;
  - `d_rvalid`, `d_rdata` = word 0x010, `stall = 0` in N+1;
  - fetch granted in N+1.
- Store `0x1234` to `0x0040`:
  - `mem_wr = 1`, `mem_addr = 0x020` in the grant cycle; no `d_rvalid`;
  - readback by a later load returns `0x1234`.
- `STARVE_LIM = 4`, `d_req` and `if_req` held high:
  - grant pattern D,D,D,D,F,D,D,D,D,F;
  - `stall` high in every cycle of the pattern: data-grant cycles are loads (`d_gnt & ~d_we`), fetch cycles have `d_req` ungranted.
- Load granted, `reset` pulsed mid-cycle before N+1:
  - all outputs 0 immediately; no `d_rvalid`; state `IDLE`.
- `if_req` dropped in the cycle `d_req` releases: no `if_gnt`, `mem_wr = 0`, state `IDLE`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter slice.
// owner_e names which requester owns the read currently in flight.
package mem_arb_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch is waiting.
// at_lim tells the arbiter to hand the next slot to fetch.
module arb_starve_ctr #(
    parameter int LIM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_lim
);

    localparam logic [3:0] LIM_V = 4'(LIM);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign at_lim = (cnt_q == LIM_V);

    // Clear dominates so a fetch grant always restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_lim) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// routing the next-cycle read data back to whichever requester issued the read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_sel,
    output logic              stall,
    output owner_e            dbg_state
);

    // Handshake: a requester raises *_req with its payload stable; the payload is
    // consumed in the cycle *_gnt is high. Reads return with *_rvalid one cycle later.

    owner_e            state_q, state_d;
    logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              at_lim;
    logic              arb_en;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, if_addr[0], d_addr[0]};

    // Grants are suppressed while reset is held so every output reads zero.
    assign arb_en = ~reset;
    assign d_gnt  = arb_en & d_req & ~(if_req & at_lim);
    assign if_gnt = arb_en & if_req & ~d_gnt;

    arb_starve_ctr #(
        .LIM (STARVE_LIM)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (d_gnt & if_req),
        .clr    (if_gnt | ~if_req),
        .at_lim (at_lim)
    );

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (d_gnt) begin
            mem_addr_d  = d_addr[ADDR_W-1:1];
            mem_wdata_d = d_wdata;
        end else if (if_gnt) begin
            mem_addr_d  = if_addr[ADDR_W-1:1];
        end
    end

    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;
    assign mem_wr    = d_gnt & d_we;
    assign mem_sel   = d_gnt;
    assign stall     = arb_en & ((d_req & ~d_gnt) | (d_gnt & ~d_we));
    assign dbg_state = state_q;

    // Owner tracking depends only on this cycle's grant, so reads can issue back to back.
    always_comb begin
        state_d   = IDLE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        if (if_gnt) begin
            state_d = RD_IF;
        end else if (d_gnt && !d_we) begin
            state_d = RD_D;
        end
        case (state_q)
            RD_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RD_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata;
            d_rdata_q   <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-2:0] mem_addr;
    logic          mem_wr, mem_sel, stall;
    logic [DW-1:0] mem_wdata, mem_rdata;
    owner_e        dbg_state;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_LIM (LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_sel   (mem_sel),
        .stall     (stall),
        .dbg_state (dbg_state)
    );

    // Synchronous single-port memory behind the arbiter.
    logic [DW-1:0] mem    [0:32767];
    logic [DW-1:0] shadow [0:32767];

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: who owns the read in flight and what it must return.
    int            m_starve;
    int            m_pend;
    logic [DW-1:0] m_rd, m_if_h, m_d_h, m_wd_h;
    logic [AW-2:0] m_addr_h;
    bit            last_dgnt, last_ifgnt;
    bit            model_on = 1'b0;

    task automatic model_reset();
        m_starve   = 0;
        m_pend     = 0;
        m_rd       = '0;
        m_if_h     = '0;
        m_d_h      = '0;
        m_wd_h     = '0;
        m_addr_h   = '0;
        last_dgnt  = 1'b0;
        last_ifgnt = 1'b0;
    endtask

    always @(negedge clk) begin : cmp
        logic          e_dg, e_ig, e_st;
        logic [AW-2:0] e_addr;
        logic [DW-1:0] e_wd, e_ifd, e_dd;
        logic [1:0]    e_state;
        if (model_on) begin
            if (reset) begin
                check("rst_if_gnt", if_gnt, 0);
                check("rst_d_gnt", d_gnt, 0);
                check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
                check("rst_rdata", {if_rdata, d_rdata}, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
                check("rst_misc", {mem_wr, mem_sel, stall}, 0);
                check("rst_state", dbg_state, IDLE);
                model_reset();
            end else begin
                e_dg    = d_req && !(if_req && m_starve == LIM);
                e_ig    = if_req && !e_dg;
                e_st    = (d_req && !e_dg) || (e_dg && !d_we);
                e_addr  = e_dg ? d_addr[AW-1:1] : (e_ig ? if_addr[AW-1:1] : m_addr_h);
                e_wd    = e_dg ? d_wdata : m_wd_h;
                e_ifd   = (m_pend == 1) ? m_rd : m_if_h;
                e_dd    = (m_pend == 2) ? m_rd : m_d_h;
                e_state = (m_pend == 1) ? RD_IF : ((m_pend == 2) ? RD_D : IDLE);
                check("if_gnt", if_gnt, e_ig);
                check("d_gnt", d_gnt, e_dg);
                check("mem_addr", mem_addr, e_addr);
                check("mem_wr", mem_wr, e_dg && d_we);
                check("mem_wdata", mem_wdata, e_wd);
                check("mem_sel", mem_sel, e_dg);
                check("stall", stall, e_st);
                check("if_rvalid", if_rvalid, m_pend == 1);
                check("d_rvalid", d_rvalid, m_pend == 2);
                check("if_rdata", if_rdata, e_ifd);
                check("d_rdata", d_rdata, e_dd);
                check("state", dbg_state, e_state);
                if (m_pend == 1) m_if_h = m_rd;
                if (m_pend == 2) m_d_h = m_rd;
                if (e_ig) begin
                    m_pend = 1;
                    m_rd   = shadow[if_addr[AW-1:1]];
                end else if (e_dg && !d_we) begin
                    m_pend = 2;
                    m_rd   = shadow[d_addr[AW-1:1]];
                end else begin
                    m_pend = 0;
                end
                if (e_dg && d_we) shadow[d_addr[AW-1:1]] = d_wdata;
                if (e_ig || !if_req) m_starve = 0;
                else if (e_dg && m_starve < LIM) m_starve++;
                m_addr_h   = e_addr;
                m_wd_h     = e_wd;
                last_dgnt  = e_dg;
                last_ifgnt = e_ig;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        d_req   = req;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic set_if(input logic req, input logic [AW-1:0] a);
        if_req  = req;
        if_addr = a;
    endtask

    initial begin : main
        logic [9:0] pat;
        reset = 1'b1;
        set_d(0, 0, '0, '0);
        set_if(0, '0);
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[8]  = 16'hA5C3;
        mem[16] = 16'h5A5A;
        for (int i = 0; i < 32768; i++) shadow[i] = mem[i];
        model_reset();
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dbg_state, IDLE);
        check("reset_mem_addr", mem_addr, 0);
        reset = 1'b0;

        // Fetch only.
        step();
        set_if(1, 16'h0010);
        #2;
        check("f_gnt", if_gnt, 1);
        check("f_mem_addr", mem_addr, 15'h008);
        check("f_mem_sel", mem_sel, 0);
        step();
        set_if(0, 16'h0010);
        #2;
        check("f_rvalid", if_rvalid, 1);
        check("f_rdata", if_rdata, 16'hA5C3);

        // Load with fetch pending.
        step();
        set_if(1, 16'h0030);
        set_d(1, 0, 16'h0020, '0);
        #2;
        check("ld_gnt", d_gnt, 1);
        check("ld_stall", stall, 1);
        check("ld_if_wait", if_gnt, 0);
        step();
        set_d(0, 0, 16'h0020, '0);
        #2;
        check("ld_rvalid", d_rvalid, 1);
        check("ld_rdata", d_rdata, 16'h5A5A);
        check("ld_stall_low", stall, 0);
        check("ld_then_fetch", if_gnt, 1);

        // Store then readback.
        step();
        set_if(0, 16'h0030);
        set_d(1, 1, 16'h0040, 16'h1234);
        #2;
        check("st_mem_wr", mem_wr, 1);
        check("st_mem_addr", mem_addr, 15'h020);
        check("st_mem_wdata", mem_wdata, 16'h1234);
        step();
        set_d(1, 0, 16'h0040, '0);
        #2;
        check("st_no_rvalid", d_rvalid, 0);
        step();
        set_d(0, 0, 16'h0040, '0);
        #2;
        check("st_readback", d_rdata, 16'h1234);

        // Starvation pattern D,D,D,D,F,D,D,D,D,F (1 = data grant).
        step();
        set_d(1, 0, 16'h0020, '0);
        set_if(1, 16'h0050);
        pat = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("sv_d_gnt", d_gnt, pat[9-i]);
            check("sv_if_gnt", if_gnt, !pat[9-i]);
            check("sv_stall", stall, 1);
            step();
        end
        set_d(0, 0, '0, '0);
        set_if(0, '0);

        // Fetch dropped as the store releases the port.
        step();
        set_d(1, 1, 16'h0060, 16'hBEEF);
        set_if(1, 16'h0070);
        step();
        set_d(0, 0, '0, '0);
        set_if(0, 16'h0070);
        #2;
        check("drop_if_gnt", if_gnt, 0);
        check("drop_mem_wr", mem_wr, 0);
        check("drop_state", dbg_state, IDLE);
        step();
        #2;
        check("drop_state_next", dbg_state, IDLE);
        check("drop_no_rvalid", if_rvalid, 0);

        // Reset hits a granted load before its data returns.
        step();
        set_d(1, 0, 16'h0020, '0);
        #2;
        check("rl_d_gnt", d_gnt, 1);
        reset = 1'b1;
        #1;
        check("rl_gnt_gated", {d_gnt, if_gnt}, 0);
        check("rl_stall", stall, 0);
        check("rl_rdata", {d_rdata, if_rdata}, 0);
        check("rl_mem_addr", mem_addr, 0);
        check("rl_state", dbg_state, IDLE);
        step();
        check("rl_no_rvalid", d_rvalid, 0);
        set_d(0, 0, '0, '0);
        reset = 1'b0;
        #2;
        check("rl_after_rvalid", d_rvalid, 0);
        check("rl_after_state", dbg_state, IDLE);

        // Randomized traffic obeying the hold-until-granted rules.
        for (int c = 0; c < 2000; c++) begin
            step();
            if (reset) reset = 1'b0;
            if (!(d_req && !last_dgnt)) begin
                set_d($urandom_range(0, 99) < 55, $urandom_range(0, 2) == 0,
                      {8'h00, 8'($urandom)}, 16'($urandom));
            end
            if (if_req && !last_ifgnt) begin
                if ($urandom_range(0, 9) == 0) if_req = 1'b0;
            end else begin
                set_if($urandom_range(0, 99) < 70, {8'h00, 8'($urandom)});
            end
            if ($urandom_range(0, 249) == 0) begin
                #2;
                reset = 1'b1;
            end
        end
        step();
        reset = 1'b0;
        set_d(0, 0, '0, '0);
        set_if(0, '0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
